seq_mag_comparator: RTL and testbench
=====================================

Name: seq_mag_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator; next generation of the four-bit combinational comparator.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle.
- Supports per-transaction signed/unsigned mode and valid/ready handshakes on request and result.
- Produces registered one-hot greater/equal/less flags; used where wide operands make a single-cycle compare too slow.

Parameters:
- WIDTH, 16, operand width in bits; must be ≥1.
- DIGIT, 4, bits compared per cycle; WIDTH % DIGIT must be 0, otherwise elaboration fails with $error.
- NCHUNK (localparam), WIDTH/DIGIT, number of slices.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  request valid.
- start_ready  output  1  block can accept a request.
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled on accept.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer takes result.
- gt  output  1  A > B.
- eq  output  1  A == B.
- lt  output  1  A < B.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE; start_ready=1; res_valid=0; gt=eq=lt=0; operand registers and slice index = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On a clk edge with start_valid=1: latch a, b and is_signed; index=NCHUNK-1; go to RUN.
- RUN:
  - start_ready=0. Each cycle compares slice [index*DIGIT +: DIGIT] of A against the same slice of B.
  - Signed mode: the sign bit of both operands is inverted before the top-slice compare; all slices are then compared unsigned.
  - Slices differ: register gt/lt (eq=0) at the end of the cycle; go to DONE.
  - Slices equal and index>0: decrement index; stay in RUN.
  - Slices equal and index==0: register eq=1 (gt=lt=0); go to DONE.
- DONE:
  - res_valid=1; flags held stable.
  - On an edge with res_ready=1: res_valid=0; go to IDLE.
  - A consumer holding res_ready high sees res_valid for exactly one cycle.
- Latency: res_valid rises k edges after the accepting edge, where k = index of the first differing slice counted from the top (1..NCHUNK). Equal operands give k=NCHUNK. DIGIT==WIDTH gives k=1.
- Throughput: one IDLE cycle between results; a new request cannot be accepted in DONE.
- Flags:
  - Exactly one of gt/eq/lt is high whenever res_valid=1.
  - Flags keep their last value after the handshake until the next result is registered.
  - Flags are only meaningful while res_valid=1.
- Input changes: a, b and is_signed may change freely after accept without affecting the result. start_valid while start_ready=0 is ignored, not queued.
- Reset mid-operation: asserting rst_n low in RUN or DONE forces the reset values immediately, regardless of clk. The in-flight result is discarded.

Optional Feature:
- Macro: SEQCMP_EARLY_EXIT_EN.
- Defined: RUN leaves as soon as a slice differs; latency 1..NCHUNK as described above.
- Undefined (constant-latency mode):
  - RUN always walks all NCHUNK slices.
  - The first differing slice's decision is captured in a sticky internal flag; later slices cannot override it.
  - res_valid rises exactly NCHUNK edges after accept for every operand pair.
  - Flag values are identical to the defined case.

Test Plan (WIDTH=16, DIGIT=4 unless stated):
- a=16'hC000, b=16'hA000, unsigned → gt=1, eq=lt=0. With early exit, res_valid 1 edge after accept; without it, 4 edges.
- a=16'h1235, b=16'h1234, unsigned → gt=1 after 4 edges. Then a=b=16'hABCD → eq=1 after 4 edges, start_ready back high one cycle after the handshake.
- a=16'h8000, b=16'h0001: is_signed=1 → lt=1; same operands with is_signed=0 → gt=1. Also a=16'hFFFF, b=16'hFFFE, signed → gt=1 (-1 > -2).
- Hold res_ready=0 for 5 cycles after res_valid:
  - res_valid and flags stay stable; start_ready=0.
  - A pulsed start_valid with a=16'h0000 is ignored.
  - After res_ready=1 there is exactly one handshake, then IDLE.
- Assert rst_n low mid-RUN (a=16'h0001, b=16'h0002, 2 edges after accept) → res_valid=0, gt=eq=lt=0, start_ready=1 asynchronously. After release, a fresh compare a=16'h0002, b=16'h0001 → gt=1.
- WIDTH=8, DIGIT=8 instance: a=8'h7F, b=8'h80, signed → gt=1 after 1 edge; unsigned → lt=1.

Source files
------------

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, signed/unsigned per request.
// Optional SEQCMP_EARLY_EXIT_EN: leave RUN on the first differing slice (default: constant NCHUNK-cycle latency).
module seq_mag_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] SIGN_MSK = WIDTH'(1) << (WIDTH - 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("seq_mag_comparator: WIDTH must be >=1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    logic [DIGIT-1:0] slice_a, slice_b;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so every slice afterwards is a plain unsigned compare.
    function automatic logic [WIDTH-1:0] bias_sign(input logic [WIDTH-1:0] v, input logic s);
        bias_sign = v ^ (s ? SIGN_MSK : '0);
    endfunction

    assign slice_a = a_q[int'(idx_q)*DIGIT +: DIGIT];
    assign slice_b = b_q[int'(idx_q)*DIGIT +: DIGIT];

`ifndef SEQCMP_EARLY_EXIT_EN
    // Sticky decision from the first differing slice; lower slices cannot override it.
    logic sgt_q, sgt_d, slt_q, slt_d;
    logic cur_gt, cur_lt;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
`ifndef SEQCMP_EARLY_EXIT_EN
        sgt_d   = sgt_q;
        slt_d   = slt_q;
        cur_gt  = sgt_q | (~slt_q & (slice_a > slice_b));
        cur_lt  = slt_q | (~sgt_q & (slice_a < slice_b));
`endif
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = bias_sign(a, is_signed);
                    b_d     = bias_sign(b, is_signed);
                    idx_d   = LAST_IDX;
                    state_d = RUN;
`ifndef SEQCMP_EARLY_EXIT_EN
                    sgt_d   = 1'b0;
                    slt_d   = 1'b0;
`endif
                end
            end
            RUN: begin
`ifdef SEQCMP_EARLY_EXIT_EN
                if (slice_a != slice_b) begin
                    gt_d    = slice_a > slice_b;
                    lt_d    = slice_a < slice_b;
                    eq_d    = 1'b0;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
`else
                sgt_d = cur_gt;
                slt_d = cur_lt;
                if (idx_q == '0) begin
                    gt_d    = cur_gt;
                    lt_d    = cur_lt;
                    eq_d    = ~cur_gt & ~cur_lt;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
`endif
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
`ifndef SEQCMP_EARLY_EXIT_EN
            sgt_q   <= 1'b0;
            slt_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
`ifndef SEQCMP_EARLY_EXIT_EN
            sgt_q   <= sgt_d;
            slt_q   <= slt_d;
`endif
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign gt          = gt_q;
    assign eq          = eq_q;
    assign lt          = lt_q;
endmodule

// File: tb/tb_seq_mag_comparator.sv
// Randomized self-checking bench for seq_mag_comparator (16/4 and 8/8 instances) against an arithmetic model.
module tb_seq_mag_comparator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sv1 = 1'b0, sr1, s1 = 1'b0, rv1, rr1 = 1'b0, gt1, eq1, lt1;
    logic [15:0] a1 = '0, b1 = '0;
    logic        sv2 = 1'b0, sr2, s2 = 1'b0, rv2, rr2 = 1'b0, gt2, eq2, lt2;
    logic [7:0]  a2 = '0, b2 = '0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    seq_mag_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1), .a(a1), .b(b1),
        .is_signed(s1), .res_valid(rv1), .res_ready(rr1), .gt(gt1), .eq(eq1), .lt(lt1));

    seq_mag_comparator #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv2), .start_ready(sr2), .a(a2), .b(b2),
        .is_signed(s2), .res_valid(rv2), .res_ready(rr2), .gt(gt2), .eq(eq2), .lt(lt2));

    // Reference: plain signed/unsigned arithmetic compare; latency = first differing prefix.
    function automatic void model16(input logic [15:0] ma, input logic [15:0] mb, input logic ms,
                                    output logic [2:0] fl, output int lat);
        logic g, l;
        if (ms) begin
            g = $signed(ma) > $signed(mb);
            l = $signed(ma) < $signed(mb);
        end else begin
            g = ma > mb;
            l = ma < mb;
        end
        fl  = {g, (ma == mb), l};
        lat = 4;
`ifdef SEQCMP_EARLY_EXIT_EN
        for (int k = 1; k <= 4; k++) begin
            if ((ma >> (16 - 4 * k)) != (mb >> (16 - 4 * k))) begin
                lat = k;
                break;
            end
        end
`endif
    endfunction

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                         output int lat, output logic [2:0] fl, output logic sr_after, output logic rv_after);
        @(negedge clk);
        a1 = ta; b1 = tb; s1 = ts; sv1 = 1'b1;
        @(posedge clk); #1;
        sv1 = 1'b0; a1 = 16'($urandom); b1 = 16'($urandom); s1 = 1'($urandom_range(0, 1));
        lat = 0;
        while (rv1 !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        fl = {gt1, eq1, lt1};
        rr1 = 1'b1;
        @(posedge clk); #1;
        rr1 = 1'b0;
        sr_after = sr1;
        rv_after = rv1;
    endtask

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                        output int lat, output logic [2:0] fl);
        @(negedge clk);
        a2 = ta; b2 = tb; s2 = ts; sv2 = 1'b1;
        @(posedge clk); #1;
        sv2 = 1'b0; a2 = 8'($urandom); b2 = 8'($urandom);
        lat = 0;
        while (rv2 !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        fl = {gt2, eq2, lt2};
        rr2 = 1'b1;
        @(posedge clk); #1;
        rr2 = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({sr1, rv1, gt1, eq1, lt1} !== 5'b10000) begin
            errors++;
            $display("FAIL reset16: got sr/rv/gt/eq/lt=%b expected 10000", {sr1, rv1, gt1, eq1, lt1});
        end
        checks++;
        if ({sr2, rv2, gt2, eq2, lt2} !== 5'b10000) begin
            errors++;
            $display("FAIL reset8: got sr/rv/gt/eq/lt=%b expected 10000", {sr2, rv2, gt2, eq2, lt2});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] va [6] = '{16'hC000, 16'h1235, 16'hABCD, 16'h8000, 16'h8000, 16'hFFFF};
        logic [15:0] vb [6] = '{16'hA000, 16'h1234, 16'hABCD, 16'h0001, 16'h0001, 16'hFFFE};
        logic        vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  vf [6] = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b100, 3'b100};
        int          lat, elat;
        logic [2:0]  fl, mfl;
        logic        sra, rva;
        for (int i = 0; i < 6; i++) begin
            run16(va[i], vb[i], vs[i], lat, fl, sra, rva);
            model16(va[i], vb[i], vs[i], mfl, elat);
            checks++;
            if (fl !== vf[i]) begin
                errors++;
                $display("FAIL directed_flags[%0d]: got gt/eq/lt=%b expected %b", i, fl, vf[i]);
            end
            checks++;
            if (lat !== elat) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, elat);
            end
            checks++;
            if ({sra, rva} !== 2'b10) begin
                errors++;
                $display("FAIL directed_handshake[%0d]: got sr/rv=%b expected 10", i, {sra, rva});
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ta, tb;
        logic        ts;
        int          lat, elat;
        logic [2:0]  fl, efl;
        logic        sra, rva;
        for (int i = 0; i < 60; i++) begin
            ta = 16'($urandom);
            ts = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: tb = 16'($urandom);
                1: tb = ta;
                2: tb = ta ^ (16'h0001 << $urandom_range(0, 15));
                default: tb = ta ^ 16'h8000;
            endcase
            run16(ta, tb, ts, lat, fl, sra, rva);
            model16(ta, tb, ts, efl, elat);
            checks++;
            if (fl !== efl) begin
                errors++;
                $display("FAIL random_flags a=%h b=%h s=%b: got %b expected %b", ta, tb, ts, fl, efl);
            end
            checks++;
            if (lat !== elat) begin
                errors++;
                $display("FAIL random_latency a=%h b=%h: got %0d expected %0d", ta, tb, lat, elat);
            end
        end
    endtask

    task automatic test_backpressure();
        int wait_cnt = 0;
        @(negedge clk);
        a1 = 16'h5000; b1 = 16'h4000; s1 = 1'b0; sv1 = 1'b1;
        @(posedge clk); #1;
        sv1 = 1'b0;
        while (rv1 !== 1'b1 && wait_cnt < 64) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        checks++;
        if (rv1 !== 1'b1) begin
            errors++;
            $display("FAIL bp_timeout: res_valid=%b expected 1", rv1);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rv1, sr1, gt1, eq1, lt1} !== 5'b10100) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got rv/sr/gt/eq/lt=%b expected 10100", i, {rv1, sr1, gt1, eq1, lt1});
            end
            if (i == 2) begin
                sv1 = 1'b1; a1 = 16'h0000; b1 = 16'h0000;
            end else begin
                sv1 = 1'b0;
            end
            @(posedge clk); #1;
        end
        sv1 = 1'b0;
        rr1 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({rv1, sr1} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: got rv/sr=%b expected 01", {rv1, sr1});
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({rv1, sr1} !== 2'b01) begin
                errors++;
                $display("FAIL bp_no_queue[%0d]: got rv/sr=%b expected 01", i, {rv1, sr1});
            end
        end
        rr1 = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int         lat;
        logic [2:0] fl;
        logic       sra, rva;
        @(negedge clk);
        a1 = 16'h0001; b1 = 16'h0002; s1 = 1'b0; sv1 = 1'b1;
        @(posedge clk); #1;
        sv1 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if ({rv1, sr1} !== 2'b00) begin
            errors++;
            $display("FAIL midrun_busy: got rv/sr=%b expected 00", {rv1, sr1});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({sr1, rv1, gt1, eq1, lt1} !== 5'b10000) begin
            errors++;
            $display("FAIL midrun_async_reset: got sr/rv/gt/eq/lt=%b expected 10000", {sr1, rv1, gt1, eq1, lt1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run16(16'h0002, 16'h0001, 1'b0, lat, fl, sra, rva);
        checks++;
        if (fl !== 3'b100) begin
            errors++;
            $display("FAIL midrun_fresh: got gt/eq/lt=%b expected 100", fl);
        end
    endtask

    task automatic test_narrow();
        int         lat;
        logic [2:0] fl;
        logic [7:0] ta, tb;
        logic       ts;
        logic [2:0] efl;
        run8(8'h7F, 8'h80, 1'b1, lat, fl);
        checks++;
        if ({fl, 8'(lat)} !== {3'b100, 8'd1}) begin
            errors++;
            $display("FAIL narrow_signed: got flags=%b lat=%0d expected 100 lat=1", fl, lat);
        end
        run8(8'h7F, 8'h80, 1'b0, lat, fl);
        checks++;
        if ({fl, 8'(lat)} !== {3'b001, 8'd1}) begin
            errors++;
            $display("FAIL narrow_unsigned: got flags=%b lat=%0d expected 001 lat=1", fl, lat);
        end
        for (int i = 0; i < 10; i++) begin
            ta = 8'($urandom);
            tb = ($urandom_range(0, 3) == 0) ? ta : 8'($urandom);
            ts = 1'($urandom_range(0, 1));
            efl = ts ? {$signed(ta) > $signed(tb), ta == tb, $signed(ta) < $signed(tb)}
                     : {ta > tb, ta == tb, ta < tb};
            run8(ta, tb, ts, lat, fl);
            checks++;
            if ({fl, 8'(lat)} !== {efl, 8'd1}) begin
                errors++;
                $display("FAIL narrow_random a=%h b=%h s=%b: got %b lat=%0d expected %b lat=1", ta, tb, ts, fl, lat, efl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_narrow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
